// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four single-byte request slots arbitrated round-robin onto one UART transmitter.
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        clk_uart,
  input  logic        rst,
  input  logic [3:0]  req_wr,
  input  logic [31:0] req_data,
  input  logic        tx_busy,
  output logic        uart_wrsig,
  output logic [7:0]  uart_datain,
  output logic [3:0]  req_full,
  output logic [3:0]  req_ovf,
  output logic [1:0]  grant_id,
  output logic        tx_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] slot [4];
  logic [1:0] sel;
  logic grant;
  // Search downward so the nearest full slot after grant_id wins.
  always_comb begin
    sel = grant_id;
    for (int k = 4; k >= 1; k--)
      if (req_full[grant_id + 2'(k)]) sel = grant_id + 2'(k);
    grant = (state == IDLE) && |req_full && !tx_busy;
  end
  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state       <= IDLE;
      uart_wrsig  <= 1'b0;
      uart_datain <= 8'h00;
      req_full    <= 4'b0;
      req_ovf     <= 4'b0;
      grant_id    <= 2'd3;
      tx_timeout  <= 1'b0;
      cnt         <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_wr[i]) begin
          if (!req_full[i] || (grant && sel == 2'(i))) begin
            slot[i]     <= req_data[8*i +: 8];
            req_full[i] <= 1'b1;
          end else req_ovf[i] <= 1'b1;
        end else if (grant && sel == 2'(i)) req_full[i] <= 1'b0;
      end
      uart_wrsig <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          uart_datain <= slot[sel];
          grant_id    <= sel;
          uart_wrsig  <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          cnt   <= CW'(1);
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (tx_busy) begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          cnt        <= '0;
          tx_timeout <= 1'b1;
          state      <= IDLE;
        end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the UART request arbiter.
module tb_uart_tx_arbiter;
  localparam int BT = 16;
  logic        clk_uart = 1'b0;
  logic        rst, tx_busy, uart_wrsig, tx_timeout;
  logic [3:0]  req_wr, req_full, req_ovf;
  logic [31:0] req_data;
  logic [7:0]  uart_datain;
  logic [1:0]  grant_id;
  int checks = 0, errors = 0, n;

  uart_tx_arbiter #(.BUSY_TIMEOUT(BT)) dut (
    .clk_uart(clk_uart), .rst(rst), .req_wr(req_wr), .req_data(req_data),
    .tx_busy(tx_busy), .uart_wrsig(uart_wrsig), .uart_datain(uart_datain),
    .req_full(req_full), .req_ovf(req_ovf), .grant_id(grant_id), .tx_timeout(tx_timeout)
  );

  always #5 clk_uart = ~clk_uart;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_uart);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    while (uart_wrsig !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    chk("strobe_seen", {31'b0, uart_wrsig}, 1);
  endtask

  task automatic finish_xfer;
    tick;
    tx_busy = 1'b1;
    tick;
    tx_busy = 1'b0;
    tick;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_wr = 4'b0; req_data = 32'h0; tx_busy = 1'b0;
    tick;
    tick;
    chk("rst_wrsig", uart_wrsig, 0);
    chk("rst_datain", uart_datain, 8'h00);
    chk("rst_full", req_full, 4'b0);
    chk("rst_ovf", req_ovf, 4'b0);
    chk("rst_grant", grant_id, 3);
    chk("rst_timeout", tx_timeout, 0);
    rst = 1'b0;

    // single request, 2-cycle latency
    req_wr = 4'b0001; req_data = 32'h0000_0031;
    tick;
    req_wr = 4'b0;
    chk("single_full", req_full, 4'b0001);
    chk("single_nostrobe", uart_wrsig, 0);
    tick;
    chk("single_wrsig", uart_wrsig, 1);
    chk("single_data", uart_datain, 8'h31);
    chk("single_grant", grant_id, 0);
    chk("single_full_clr", req_full, 4'b0);
    tick;
    chk("single_one_cycle", uart_wrsig, 0);
    chk("single_hold", uart_datain, 8'h31);
    tx_busy = 1'b1;
    tick;
    tx_busy = 1'b0;
    tick;

    // round robin with a 10-cycle busy transmitter
    do_reset;
    req_wr = 4'hf; req_data = 32'h3433_3231;
    tick;
    req_wr = 4'b0;
    chk("rr_full", req_full, 4'hf);
    for (int j = 0; j < 4; j++) begin
      wait_strobe(n);
      chk("rr_latency", n, (j == 0) ? 1 : 2);
      chk("rr_data", uart_datain, 8'h31 + j);
      chk("rr_grant", grant_id, j);
      tick;
      tx_busy = 1'b1;
      for (int c = 0; c < 10; c++) begin
        chk("rr_quiet", uart_wrsig, 0);
        tick;
      end
      tx_busy = 1'b0;
    end
    chk("rr_empty", req_full, 4'b0);
    tick;
    tick;

    // overflow while transmitter busy
    tx_busy = 1'b1;
    req_wr = 4'b0100; req_data = 32'h0041_0000;
    tick;
    req_data = 32'h0042_0000;
    tick;
    req_wr = 4'b0;
    chk("ovf_flag", req_ovf, 4'b0100);
    chk("ovf_full", req_full, 4'b0100);
    tick;
    chk("ovf_idle_busy", uart_wrsig, 0);
    tx_busy = 1'b0;
    wait_strobe(n);
    chk("ovf_latency", n, 1);
    chk("ovf_data", uart_datain, 8'h41);
    chk("ovf_grant", grant_id, 2);
    chk("ovf_sticky", req_ovf, 4'b0100);
    finish_xfer;

    // refill in the grant cycle
    do_reset;
    chk("refill_ovf_rst", req_ovf, 4'b0);
    req_wr = 4'b0010; req_data = 32'h0000_5000;
    tick;
    req_data = 32'h0000_5500;
    tick;
    req_wr = 4'b0;
    chk("refill_wrsig", uart_wrsig, 1);
    chk("refill_old", uart_datain, 8'h50);
    chk("refill_full", req_full, 4'b0010);
    chk("refill_ovf", req_ovf, 4'b0);
    finish_xfer;
    wait_strobe(n);
    chk("refill_latency", n, 1);
    chk("refill_new", uart_datain, 8'h55);
    chk("refill_grant", grant_id, 1);
    chk("refill_ovf2", req_ovf, 4'b0);
    finish_xfer;

    // busy timeout, then next pending slot
    req_wr = 4'b0101; req_data = 32'h0062_0060;
    tick;
    req_wr = 4'b0;
    wait_strobe(n);
    chk("to_data", uart_datain, 8'h62);
    chk("to_grant", grant_id, 2);
    for (int c = 1; c < BT; c++) begin
      tick;
      chk("to_early", tx_timeout, 0);
    end
    tick;
    chk("to_set", tx_timeout, 1);
    wait_strobe(n);
    chk("to_next_latency", n, 1);
    chk("to_next_data", uart_datain, 8'h60);
    chk("to_next_grant", grant_id, 0);

    // reset during WAIT_DONE with pending slots
    do_reset;
    chk("rst2_timeout", tx_timeout, 0);
    req_wr = 4'hf; req_data = 32'h7372_7170;
    tick;
    req_wr = 4'b0;
    wait_strobe(n);
    chk("rst2_data", uart_datain, 8'h70);
    tick;
    tx_busy = 1'b1;
    tick;
    chk("rst2_pending", req_full, 4'b1110);
    rst = 1'b1; req_wr = 4'hf; req_data = 32'hffff_ffff;
    tick;
    rst = 1'b0; req_wr = 4'b0; tx_busy = 1'b0;
    chk("rst2_full", req_full, 4'b0);
    chk("rst2_wrsig", uart_wrsig, 0);
    chk("rst2_grant", grant_id, 3);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      n += uart_wrsig;
    end
    chk("rst2_no_strobe", n, 0);
    req_wr = 4'b1000; req_data = 32'h8000_0000;
    tick;
    req_wr = 4'b0;
    wait_strobe(n);
    chk("rst2_new_latency", n, 1);
    chk("rst2_new_data", uart_datain, 8'h80);
    chk("rst2_new_grant", grant_id, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 16: max cycles waited after the write strobe for tx_busy to rise.
REQ-002 SHALL have port clk_uart  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_wr  input  4  one-cycle write strobe per requester i (0..3).
REQ-005 SHALL have port req_data  input  32  byte for requester i on bits [8i+7:8i], sampled when req_wr[i]=1.
REQ-006 SHALL have port tx_busy  input  1  UART transmitter busy, high while a frame is shifting out.
REQ-007 SHALL have port uart_wrsig  output  1  registered one-cycle write strobe to the transmitter.
REQ-008 SHALL have port uart_datain  output  8  registered byte to the transmitter.
REQ-009 SHALL have port req_full  output  4  slot i holds an unsent byte.
REQ-010 SHALL have port req_ovf  output  4  sticky: a byte for slot i was dropped.
REQ-011 SHALL have port grant_id  output  2  index of the most recently granted slot.
REQ-012 SHALL have port tx_timeout  output  1  sticky: tx_busy never rose within BUSY_TIMEOUT.

Function
REQ-013 SHALL hold one 8-bit slot per requester; if req_wr[i]=1 and req_full[i]=0, the byte is stored and req_full[i]=1 from the next cycle.
REQ-014 SHALL drop the byte and set req_ovf[i] when req_wr[i]=1 while req_full[i]=1 and the slot is not granted in that cycle; the stored byte is unchanged.
REQ-015 SHALL accept the write when req_wr[i]=1 in the same cycle slot i is granted: the old byte goes to uart_datain, the new byte is stored, req_full[i] stays 1, and req_ovf[i] is not set.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-017 SHALL, in IDLE with any req_full bit set and tx_busy=0, grant one slot, load uart_datain with its byte, clear its req_full bit, update grant_id, and go to ISSUE.
REQ-018 SHALL remain in IDLE while tx_busy=1, even if slots are full.
REQ-019 SHALL select the grant round-robin, searching grant_id+1, +2, +3, +4 (mod 4) and taking the first full slot.
REQ-020 SHALL drive uart_wrsig=1 for exactly the one cycle spent in ISSUE, then go to WAIT_BUSY.
REQ-021 SHALL, in WAIT_BUSY, go to WAIT_DONE when tx_busy=1.
REQ-022 SHALL, in WAIT_BUSY, count cycles and, if the count reaches BUSY_TIMEOUT without tx_busy=1, set tx_timeout and go to IDLE.
REQ-023 SHALL, in WAIT_DONE, go to IDLE on the first cycle with tx_busy=0.
REQ-024 SHALL hold uart_datain stable from the grant until the next grant.
REQ-025 SHALL give latency of 2 cycles when the FSM is idle and tx_busy=0: req_wr[i] in cycle t, req_full[i]=1 in t+1, uart_wrsig=1 in t+2.
REQ-026 SHALL issue at most one uart_wrsig per completed or timed-out transfer; no second strobe occurs until IDLE is re-entered.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force: state IDLE, uart_wrsig=0, uart_datain=8'h00, req_full=0, req_ovf=0, grant_id=2'd3, tx_timeout=0, timeout counter=0.
REQ-028 SHALL, when rst is asserted mid-transfer, abandon the transfer and discard all pending bytes, with no further uart_wrsig.
REQ-029 SHALL give rst priority over every req_wr in the same cycle.

Verification
REQ-030 Single request: after reset, req_wr=4'b0001 with byte 8'h31 -> uart_wrsig high for one cycle 2 cycles later with uart_datain=8'h31, grant_id=0, req_full=0.
REQ-031 Round-robin: slots 0..3 loaded simultaneously with 8'h31..8'h34; model tx_busy high for 10 cycles after each strobe -> bytes sent in order 31,32,33,34, each strobe only after tx_busy returns low.
REQ-032 Overflow: two writes to slot 2 (8'h41, then 8'h42) while tx_busy=1 -> req_ovf=4'b0100, and 8'h41 is transmitted once tx_busy falls.
REQ-033 Same-cycle refill: req_wr[1] with 8'h55 in the grant cycle of slot 1 (holding 8'h50) -> 8'h50 sent, 8'h55 sent on the next grant of slot 1, and req_ovf[1]=0.
REQ-034 Timeout: tx_busy held at 0 -> tx_timeout=1 exactly BUSY_TIMEOUT cycles after the strobe, the FSM returns to IDLE, and the next pending slot is granted.
REQ-035 Reset mid-operation: rst asserted during WAIT_DONE with 3 slots full -> next cycle req_full=0, uart_wrsig=0, and no strobe until a new req_wr.
